// File: rtl/gomoku_pkg.sv
// Shared board types: cell codes, line directions, checker FSM states, direction deltas.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gomoku_pkg;

    localparam int BOARD_DIM = 16;
    localparam int COORD_W   = 4;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10,
        CELL_RSVD  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        DIR_H = 2'd0,   // +x
        DIR_V = 2'd1,   // +y
        DIR_D = 2'd2,   // +x +y
        DIR_A = 2'd3    // +x -y
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    // Unit step of the positive side of a direction.
    function automatic delta_t dir_delta(input dir_t dir);
        delta_t d;
        case (dir)
            DIR_H:   begin d.dx = 2'sd1; d.dy = 2'sd0;  end
            DIR_V:   begin d.dx = 2'sd0; d.dy = 2'sd1;  end
            DIR_D:   begin d.dx = 2'sd1; d.dy = 2'sd1;  end
            default: begin d.dx = 2'sd1; d.dy = -2'sd1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/five_in_row_checker_if.sv
// Bundle between the game environment (controller + board read mux) and the win checker.
// Latency: none (wiring only).
// Backpressure: start is a one-shot request, ignored by the checker while busy.
interface five_in_row_checker_if #(
    parameter int COORD_W = gomoku_pkg::COORD_W
);
    logic                   start;
    logic [COORD_W-1:0]     move_x;
    logic [COORD_W-1:0]     move_y;
    logic [1:0]             player;
    logic [2*COORD_W-1:0]   rd_select;
    logic [1:0]             rd_data;
    logic                   busy;
    logic                   done;
    logic                   win;
    logic [1:0]             win_dir;

    // Environment side: issues moves and answers board reads.
    modport master (
        output start, move_x, move_y, player, rd_data,
        input  rd_select, busy, done, win, win_dir
    );

    // Checker side.
    modport slave (
        input  start, move_x, move_y, player, rd_data,
        output rd_select, busy, done, win, win_dir
    );
endinterface

// File: rtl/win_dir_stepper.sv
// Candidate cell generator: origin + step * side * delta(dir), with edge detection.
// Latency: purely combinational.
// Backpressure: none.
module win_dir_stepper
    import gomoku_pkg::*;
#(
    parameter int BOARD_DIM = gomoku_pkg::BOARD_DIM,
    parameter int COORD_W   = gomoku_pkg::COORD_W,
    parameter int STEP_W    = 3
) (
    input  logic [COORD_W-1:0]   org_x,
    input  logic [COORD_W-1:0]   org_y,
    input  dir_t                 dir,
    input  logic                 side_neg,
    input  logic [STEP_W-1:0]    step,
    output logic [2*COORD_W-1:0] cand_sel,
    output logic                 in_bounds
);
    // One extra sign bit: the walk stops at the first off-board cell, so a
    // candidate is never more than one cell past an edge and cannot alias.
    localparam int SW = COORD_W + 1;

    delta_t               delta;
    logic signed [SW-1:0] step_s;
    logic signed [SW-1:0] off_x;
    logic signed [SW-1:0] off_y;
    logic signed [SW-1:0] cand_x;
    logic signed [SW-1:0] cand_y;

    // Signed offset per axis, flipped for the negative side, then bounds check.
    always_comb begin
        delta  = dir_delta(dir);
        step_s = signed'(SW'(step));
        off_x  = '0;
        off_y  = '0;
        if (delta.dx != '0) off_x = (delta.dx[1] != side_neg) ? -step_s : step_s;
        if (delta.dy != '0) off_y = (delta.dy[1] != side_neg) ? -step_s : step_s;
        cand_x    = signed'({1'b0, org_x}) + off_x;
        cand_y    = signed'({1'b0, org_y}) + off_y;
        in_bounds = !cand_x[SW-1] && (int'(cand_x) < BOARD_DIM) &&
                    !cand_y[SW-1] && (int'(cand_y) < BOARD_DIM);
        cand_sel  = {cand_x[COORD_W-1:0], cand_y[COORD_W-1:0]};
    end
endmodule

// File: rtl/five_in_row_checker.sv
// Walks out from a placed stone in 4 directions and reports a run of >= WIN_LEN.
// Latency: 1 cycle per board read, 8*(WIN_LEN-1) reads max; done one cycle after the last read.
// Backpressure: start ignored while scanning or finishing; busy high during the scan.
module five_in_row_checker
    import gomoku_pkg::*;
#(
    parameter int BOARD_DIM = gomoku_pkg::BOARD_DIM,
    parameter int COORD_W   = gomoku_pkg::COORD_W,
    parameter int WIN_LEN   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    five_in_row_checker_if.slave bus
);
    localparam int STEP_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam int RUN_W  = $clog2(2 * WIN_LEN);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIN_LEN - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(2 * WIN_LEN - 1);
    localparam logic [RUN_W-1:0]  RUN_WIN   = RUN_W'(WIN_LEN);

    fsm_state_t           state;
    logic [COORD_W-1:0]   org_x;
    logic [COORD_W-1:0]   org_y;
    cell_t                mover;
    dir_t                 dir;
    logic                 side_neg;
    logic [STEP_W-1:0]    step;
    logic [RUN_W-1:0]     run;
    logic [2*COORD_W-1:0] sel_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 win_q;
    dir_t                 win_dir_q;

    logic [2*COORD_W-1:0] cand_sel;
    logic                 in_bounds;
    logic                 scan_read;
    logic                 hit;
    logic                 side_end;
    logic [RUN_W-1:0]     run_next;

    win_dir_stepper #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W),
        .STEP_W    (STEP_W)
    ) u_stepper (
        .org_x     (org_x),
        .org_y     (org_y),
        .dir       (dir),
        .side_neg  (side_neg),
        .step      (step),
        .cand_sel  (cand_sel),
        .in_bounds (in_bounds)
    );

    // The mux answers in the same cycle, so the select is the live candidate
    // during an on-board scan cycle and otherwise holds the last cell read.
    assign scan_read     = (state == ST_SCAN) && in_bounds;
    assign bus.rd_select = scan_read ? cand_sel : sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.win       = win_q;
    assign bus.win_dir   = win_dir_q;

    // A side ends on an off-board cell, a non-matching cell, or after WIN_LEN-1 matches.
    always_comb begin
        hit      = scan_read && (bus.rd_data == mover);
        side_end = (state == ST_SCAN) && (!hit || (step == STEP_LAST));
        run_next = run;
        if (hit && (run != RUN_MAX)) run_next = run + RUN_ONE;
    end

    // Control FSM: accept a move, walk both sides of each direction, report.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            org_x     <= '0;
            org_y     <= '0;
            mover     <= CELL_EMPTY;
            dir       <= DIR_H;
            side_neg  <= 1'b0;
            step      <= STEP_ONE;
            run       <= RUN_ONE;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            win_dir_q <= DIR_H;
        end else begin
            sel_q  <= bus.rd_select;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_q     <= 1'b0;
                        win_dir_q <= DIR_H;
                        if (bus.player == CELL_P1 || bus.player == CELL_P2) begin
                            org_x    <= bus.move_x;
                            org_y    <= bus.move_y;
                            mover    <= cell_t'(bus.player);
                            dir      <= DIR_H;
                            side_neg <= 1'b0;
                            step     <= STEP_ONE;
                            run      <= RUN_ONE;
                            busy_q   <= 1'b1;
                            state    <= ST_SCAN;
                        end else begin
                            // Not a real mover: report no win without reading the board.
                            done_q <= 1'b1;
                            state  <= ST_FINISH;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!side_end) begin
                        run  <= run_next;
                        step <= step + STEP_ONE;
                    end else if (!side_neg) begin
                        run      <= run_next;
                        side_neg <= 1'b1;
                        step     <= STEP_ONE;
                    end else if (run_next >= RUN_WIN) begin
                        win_q     <= 1'b1;
                        win_dir_q <= dir;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= ST_FINISH;
                    end else if (dir == DIR_A) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_FINISH;
                    end else begin
                        dir      <= dir_t'(dir + 2'd1);
                        run      <= RUN_ONE;
                        side_neg <= 1'b0;
                        step     <= STEP_ONE;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_five_in_row_checker.sv
// Scoreboard bench: a line-walking reference model predicts every read select and the result.
// Latency: checks done arrives exactly (reads + 1) cycles after the accepted start.
// Backpressure: exercises starts issued while busy and during the done cycle.
module tb_five_in_row_checker;
    import gomoku_pkg::*;

    localparam int WIN_LEN = 5;
    localparam int DIM     = 16;

    typedef struct {
        int t0;
        int lat;
        int win;
        int dir;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    five_in_row_checker_if #(.COORD_W(4)) bus();

    five_in_row_checker #(
        .BOARD_DIM (DIM),
        .COORD_W   (4),
        .WIN_LEN   (WIN_LEN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [1:0] board [DIM][DIM];
    assign bus.rd_data = board[bus.rd_select[7:4]][bus.rd_select[3:0]];

    int   tb_dx [4] = '{1, 0, 1, 1};
    int   tb_dy [4] = '{0, 1, 1, -1};
    exp_t res_q [$];
    int   sel_q [$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   prev_sel = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                board[i][j] = 2'b00;
    endtask

    // Reference: walk each line outward cell by cell, one read per visited cell.
    task automatic model(input int x, input int y, input int p, input int t0, output int lat);
        int   cycles, run, cx, cy, w, wd;
        exp_t e;
        cycles = 0; w = 0; wd = 0;
        if (p == 1 || p == 2) begin
            for (int d = 0; d < 4 && w == 0; d++) begin
                run = 1;
                for (int s = 1; s >= -1; s -= 2) begin
                    for (int k = 1; k < WIN_LEN; k++) begin
                        cx = x + s * k * tb_dx[d];
                        cy = y + s * k * tb_dy[d];
                        cycles++;
                        if (cx < 0 || cx >= DIM || cy < 0 || cy >= DIM) begin
                            sel_q.push_back(prev_sel);
                            break;
                        end
                        prev_sel = cx * DIM + cy;
                        sel_q.push_back(prev_sel);
                        if (int'(board[cx][cy]) != p) break;
                        run++;
                    end
                end
                if (run >= WIN_LEN) begin
                    w  = 1;
                    wd = d;
                end
            end
        end
        lat   = cycles + 1;
        e.t0  = t0;
        e.lat = lat;
        e.win = w;
        e.dir = wd;
        res_q.push_back(e);
    endtask

    // Monitor: one expected select per busy cycle, one expected result per done pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.busy) begin
                chk("sel_expected", int'(sel_q.size() > 0), 1);
                if (sel_q.size() > 0) chk("rd_select", int'(bus.rd_select), sel_q.pop_front());
            end
            if (bus.done) begin
                n_done++;
                chk("done_expected", int'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    mon_e = res_q.pop_front();
                    chk("win", int'(bus.win), mon_e.win);
                    chk("win_dir", int'(bus.win_dir), mon_e.dir);
                    chk("latency", cyc - mon_e.t0, mon_e.lat);
                    chk("busy_at_done", int'(bus.busy), 0);
                end
            end
        end
    end

    // mode 0 plain, 1 extra start while busy, 2 extra start in done cycle, 3 reset at scan cycle 3
    task automatic do_move(input int x, input int y, input int p, input int mode);
        int t0, lat, nd0, budget;
        @(posedge clock); #1;
        t0  = cyc;
        nd0 = n_done;
        if (p == 1 || p == 2) board[x][y] = 2'(p);
        model(x, y, p, t0, lat);
        bus.start  = 1'b1;
        bus.move_x = 4'(x);
        bus.move_y = 4'(y);
        bus.player = 2'(p);
        @(posedge clock); #1;
        bus.start = 1'b0;
        if (mode == 1) begin
            @(posedge clock); #1;
            bus.start  = 1'b1;
            bus.move_x = 4'(x ^ 5);
            @(posedge clock); #1;
            bus.start = 1'b0;
        end else if (mode == 2) begin
            while (cyc < t0 + lat) begin @(posedge clock); #1; end
            bus.start  = 1'b1;
            bus.player = 2'd1;
            @(posedge clock); #1;
            bus.start = 1'b0;
        end else if (mode == 3) begin
            while (cyc < t0 + 3) begin @(posedge clock); #1; end
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            sel_q.delete();
            res_q.delete();
            prev_sel = 0;
            @(negedge clock);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_win", int'(bus.win), 0);
            chk("rst_win_dir", int'(bus.win_dir), 0);
            chk("rst_rd_select", int'(bus.rd_select), 0);
            repeat (12) @(posedge clock);
            #1;
            chk("no_done_after_reset", n_done - nd0, 0);
            return;
        end
        budget = 0;
        while (n_done == nd0 && budget < 100) begin
            @(posedge clock); #1;
            budget++;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("done_count", n_done - nd0, 1);
        chk("idle_busy", int'(bus.busy), 0);
        chk("sel_hold", int'(bus.rd_select), prev_sel);
    endtask

    initial begin
        int x, y, p, d, off, cx, cy, r;
        bus.start  = 1'b0;
        bus.move_x = '0;
        bus.move_y = '0;
        bus.player = '0;
        clear_board();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_win", int'(bus.win), 0);
        chk("reset_win_dir", int'(bus.win_dir), 0);
        chk("reset_rd_select", int'(bus.rd_select), 0);
        reset = 1'b0;

        // Empty board, centre move.
        do_move(7, 7, 1, 0);
        // Horizontal win completed from the right end.
        clear_board();
        for (int i = 3; i <= 6; i++) board[i][7] = 2'b01;
        do_move(7, 7, 1, 0);
        chk("win_held", int'(bus.win), 1);
        // Corner move: negative sides fall off the board.
        clear_board();
        do_move(0, 0, 1, 0);
        // Anti-diagonal win for player 2.
        clear_board();
        board[1][14] = 2'b10; board[2][13] = 2'b10;
        board[4][11] = 2'b10; board[5][10] = 2'b10;
        do_move(3, 12, 2, 0);
        chk("anti_win_held", int'(bus.win), 1);
        // Run of four broken by an opponent stone.
        clear_board();
        board[3][5] = 2'b01; board[4][5] = 2'b01; board[5][5] = 2'b01;
        board[7][5] = 2'b10; board[8][5] = 2'b01;
        do_move(6, 5, 1, 0);
        // Reserved player code: immediate no-win.
        do_move(4, 4, 3, 0);
        // Reset in the middle of a scan.
        clear_board();
        do_move(7, 7, 1, 3);
        // Start pulses while busy and during the done cycle are ignored.
        do_move(7, 7, 1, 1);
        do_move(9, 2, 2, 2);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    r = int'($urandom_range(0, 7));
                    board[i][j] = (r < 4) ? 2'b00 : ((r < 6) ? 2'b01 : 2'b10);
                end
            x = int'($urandom_range(0, DIM - 1));
            y = int'($urandom_range(0, DIM - 1));
            r = int'($urandom_range(0, 19));
            p = (r == 0) ? 0 : ((r == 1) ? 3 : 1 + (r % 2));
            if ((p == 1 || p == 2) && $urandom_range(0, 1) == 1) begin
                d   = int'($urandom_range(0, 3));
                off = int'($urandom_range(0, WIN_LEN - 1));
                for (int k = 0; k < WIN_LEN; k++) begin
                    cx = x + (k - off) * tb_dx[d];
                    cy = y + (k - off) * tb_dy[d];
                    if (cx >= 0 && cx < DIM && cy >= 0 && cy < DIM) board[cx][cy] = 2'(p);
                end
            end
            do_move(x, y, p, int'($urandom_range(0, 2)));
        end

        chk("leftover_results", res_q.size(), 0);
        chk("leftover_selects", sel_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
